regbank_write_arbiter: RTL and testbench

Round-robin arbiter that shares the register bank's single write port between two writeback requesters (requester 0: ALU writeback, requester 1: memory-load writeback). Each requester has a small in-order queue. The arbiter drains one entry per cycle into registered `wr_en/wr_addr/wr_data` outputs that drive the bank's `regwrite/writeregister/datain`. It also reports read-after-write hazards, so issue logic can stall reads of registers whose writes are still in flight.

---
 rtl/regbank_write_arbiter.sv | 119 +++++++++++
 tb/tb_regbank_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between ALU (0) and
// load (1) writeback queues, with read-after-write hazard reporting.
module regbank_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_hazard1,
  output logic              rd_hazard2,
  output logic              busy
);
  localparam int NQ = 2;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NQ-1:0]             push, pop, rdy, nempty, hit1, hit2;
  logic [NQ-1:0][ADDR_W-1:0] in_addr, head_addr;
  logic [NQ-1:0][DATA_W-1:0] in_data, head_data;
  logic                      last_grant, grant;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_addr = {req1_addr, req0_addr};
  assign in_data = {req1_data, req0_data};
  assign push    = {req1_valid & rdy[1], req0_valid & rdy[0]};

  for (genvar q = 0; q < NQ; q++) begin : g_q
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][ADDR_W-1:0] a_mem;
    logic [DEPTH-1:0][DATA_W-1:0] d_mem;
    logic [PW-1:0]                wp, rp;
    logic                         h1, h2;

    // Per-entry valid bits make "full" and hazard matching direct lookups.
    assign rdy[q]       = ~&vld;
    assign nempty[q]    = |vld;
    assign head_addr[q] = a_mem[rp];
    assign head_data[q] = d_mem[rp];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld <= '0;
        wp  <= '0;
        rp  <= '0;
      end else begin
        if (push[q]) begin
          vld[wp] <= 1'b1;
          wp      <= inc(wp);
        end
        if (pop[q]) begin
          vld[rp] <= 1'b0;
          rp      <= inc(rp);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push[q]) begin
        a_mem[wp] <= in_addr[q];
        d_mem[wp] <= in_data[q];
      end
    end

    always_comb begin
      h1 = 1'b0;
      h2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && a_mem[i] == rd_addr1) h1 = 1'b1;
        if (vld[i] && a_mem[i] == rd_addr2) h2 = 1'b1;
      end
    end

    assign hit1[q] = h1;
    assign hit2[q] = h2;
  end

  // Queue 1 wins when it is alone, or on a tie when queue 0 was granted last.
  assign grant  = nempty[1] & (~nempty[0] | ~last_grant);
  assign pop[0] = nempty[0] & ~grant;
  assign pop[1] = grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= |pop;
      if (|pop) begin
        last_grant <= grant;
        wr_addr    <= head_addr[grant];
        wr_data    <= head_data[grant];
      end
    end
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign rd_hazard1 = |hit1 | (wr_en && wr_addr == rd_addr1);
  assign rd_hazard2 = |hit2 | (wr_en && wr_addr == rd_addr2);
  assign busy       = |nempty | wr_en;
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench: expected bank writes are queued as stimulus is driven and
// checked in order whenever the arbiter raises wr_en.
module tb_regbank_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic          rd_hazard1, rd_hazard2, busy;

  regbank_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_hazard1(rd_hazard1), .rd_hazard2(rd_hazard2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [DW-1:0] bank [32];
  int            vecs = 0, errs = 0;
  int            stall [2];

  // Bank model and scoreboard checker.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
          errs++;
          $display("FAIL write_order: got addr %0d data %h, expected addr %0d data %h",
                   wr_addr, wr_data, mon_e.a, mon_e.d);
        end
      end
      bank[wr_addr] = wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Holds a request until it is accepted at an edge; counts refused edges.
  task automatic drive(input bit which, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    int   n = 0;
    if (which) begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    else       begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    do begin
      acc = which ? req1_ready : req0_ready;
      step();
      if (!acc) stall[which]++;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errs++;
      $display("FAIL push_timeout: req%0d never ready, expected acceptance", which);
    end
    if (which) req1_valid = 1'b0;
    else       req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      step();
      n++;
    end
    vecs++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL drain: %0d writes outstanding busy=%b, expected 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rd_addr1 = '0;
    rd_addr2 = 5'd5;
    step();
    step();
    vecs += 9;
    if (req0_ready !== 1'b1) begin errs++; $display("FAIL rst_ready0: got %b expected 1", req0_ready); end
    if (req1_ready !== 1'b1) begin errs++; $display("FAIL rst_ready1: got %b expected 1", req1_ready); end
    if (wr_en !== 1'b0)      begin errs++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    if (wr_addr !== '0)      begin errs++; $display("FAIL rst_wr_addr: got %0d expected 0", wr_addr); end
    if (wr_data !== '0)      begin errs++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
    if (busy !== 1'b0)       begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (rd_hazard1 !== 1'b0) begin errs++; $display("FAIL rst_hz1: got %b expected 0", rd_hazard1); end
    if (rd_hazard2 !== 1'b0) begin errs++; $display("FAIL rst_hz2: got %b expected 0", rd_hazard2); end
    rd_addr1 = 5'd31;
    #1;
    if (rd_hazard1 !== 1'b0) begin errs++; $display("FAIL rst_hz1_addr31: got %b expected 0", rd_hazard1); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    expect_wr(5'd5, 64'hAA);
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hAA;
    step();
    req0_valid = 1'b0;
    vecs += 7;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL single_e0: got wr_en=%b busy=%b expected 0 1", wr_en, busy);
    end
    step();
    if (wr_en !== 1'b1)     begin errs++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
    if (wr_addr !== 5'd5)   begin errs++; $display("FAIL single_addr: got %0d expected 5", wr_addr); end
    if (wr_data !== 64'hAA) begin errs++; $display("FAIL single_data: got %h expected aa", wr_data); end
    step();
    if (wr_en !== 1'b0)     begin errs++; $display("FAIL single_wr_en_off: got %b expected 0", wr_en); end
    if (busy !== 1'b0)      begin errs++; $display("FAIL single_busy_off: got %b expected 0", busy); end
    if (wr_addr !== 5'd5)   begin errs++; $display("FAIL single_addr_hold: got %0d expected 5", wr_addr); end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      expect_wr(AW'(i), DW'(64'h100 + i));
      expect_wr(AW'(10 + i), DW'(64'h200 + i));
    end
    fork
      for (int i = 1; i <= 3; i++) drive(1'b0, AW'(i), DW'(64'h100 + i));
      for (int j = 1; j <= 3; j++) drive(1'b1, AW'(10 + j), DW'(64'h200 + j));
      begin
        int n = 0;
        while (wr_en !== 1'b1 && n < 20) begin step(); n++; end
        for (int k = 0; k < 6; k++) begin
          vecs++;
          if (wr_en !== 1'b1) begin
            errs++; $display("FAIL rr_back_to_back: cycle %0d got wr_en=%b expected 1", k, wr_en);
          end
          step();
        end
      end
    join
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    stall[0] = 0;
    stall[1] = 0;
    for (int i = 0; i < 4; i++) begin
      expect_wr(AW'(20 + i), DW'(64'hA0 + i));
      expect_wr(AW'(24 + i), DW'(64'hB0 + i));
    end
    fork
      for (int i = 0; i < 4; i++) drive(1'b0, AW'(20 + i), DW'(64'hA0 + i));
      for (int j = 0; j < 4; j++) drive(1'b1, AW'(24 + j), DW'(64'hB0 + j));
    join
    drain();
    vecs += 2;
    if (stall[0] != 1) begin errs++; $display("FAIL bp_stall0: got %0d refused edges expected 1", stall[0]); end
    if (stall[1] != 2) begin errs++; $display("FAIL bp_stall1: got %0d refused edges expected 2", stall[1]); end
  endtask

  task automatic test_hazard();
    do_reset();
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd8;
    #1;
    vecs += 7;
    if (rd_hazard1 !== 1'b0) begin errs++; $display("FAIL hz_idle: got %b expected 0", rd_hazard1); end
    expect_wr(5'd7, 64'h77);
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h77;
    step();
    req0_valid = 1'b0;
    if (rd_hazard1 !== 1'b1) begin errs++; $display("FAIL hz_queued1: got %b expected 1", rd_hazard1); end
    if (rd_hazard2 !== 1'b0) begin errs++; $display("FAIL hz_queued2: got %b expected 0", rd_hazard2); end
    rd_addr2 = 5'd7;
    #1;
    if (rd_hazard2 !== 1'b1) begin errs++; $display("FAIL hz_comb2: got %b expected 1", rd_hazard2); end
    rd_addr2 = 5'd8;
    step();
    if (wr_en !== 1'b1 || rd_hazard1 !== 1'b1) begin
      errs++; $display("FAIL hz_wr_cycle: got wr_en=%b hz1=%b expected 1 1", wr_en, rd_hazard1);
    end
    if (rd_hazard2 !== 1'b0) begin errs++; $display("FAIL hz_wr_cycle2: got %b expected 0", rd_hazard2); end
    step();
    if (rd_hazard1 !== 1'b0) begin errs++; $display("FAIL hz_cleared: got %b expected 0", rd_hazard1); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    expect_wr(5'd3, 64'hA0);
    expect_wr(5'd4, 64'hB0);
    req0_valid = 1'b1; req0_addr = 5'd3;  req0_data = 64'hA0;
    req1_valid = 1'b1; req1_addr = 5'd4;  req1_data = 64'hB0;
    step();
    req0_addr = 5'd6;  req0_data = 64'hA1;
    req1_addr = 5'd12; req1_data = 64'hB1;
    step();
    req0_addr = 5'd10; req0_data = 64'hA2;
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b0;
    rd_addr1 = 5'd10;
    rd_addr2 = 5'd4;
    #1;
    vecs += 8;
    if (wr_en !== 1'b1 || wr_addr !== 5'd4) begin
      errs++; $display("FAIL mid_pre_wr: got wr_en=%b addr=%0d expected 1 4", wr_en, wr_addr);
    end
    if (rd_hazard1 !== 1'b1 || rd_hazard2 !== 1'b1) begin
      errs++; $display("FAIL mid_pre_hz: got %b %b expected 1 1", rd_hazard1, rd_hazard2);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    if (wr_en !== 1'b0) begin errs++; $display("FAIL mid_wr_en: got %b expected 0", wr_en); end
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
      errs++; $display("FAIL mid_ready: got %b %b expected 1 1", req0_ready, req1_ready);
    end
    if (rd_hazard1 !== 1'b0 || rd_hazard2 !== 1'b0) begin
      errs++; $display("FAIL mid_hz: got %b %b expected 0 0", rd_hazard1, rd_hazard2);
    end
    if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (wr_addr !== '0 || wr_data !== '0) begin
      errs++; $display("FAIL mid_wr_regs: got %0d %h expected 0 0", wr_addr, wr_data);
    end
    for (int i = 0; i < 6; i++) step();
    if (exp_q.size() != 0) begin errs++; $display("FAIL mid_sb: %0d writes missing expected 0", exp_q.size()); end
  endtask

  task automatic test_same_addr();
    do_reset();
    bank[9] = '0;
    expect_wr(5'd9, 64'h1);
    expect_wr(5'd9, 64'h2);
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 64'h1;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'h2;
    step();
    req0_valid = 1'b0;
    drain();
    vecs++;
    if (bank[9] !== 64'h2) begin errs++; $display("FAIL same_addr_bank: got %h expected 2", bank[9]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hazard();
    test_reset_mid();
    test_same_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
